// File: rtl/led_breathe_pwm_pkg.sv
// Shared types and constants for the LED breathing stage: FSM state encoding,
// mode values and a counter-width helper.
package led_breathe_pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD_HI   = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_HOLD_LO   = 3'd4,
        ST_FOLLOW    = 3'd5
    } led_state_t;

    localparam logic MODE_BREATHE = 1'b0;
    localparam logic MODE_FOLLOW  = 1'b1;

    // Width of a counter that counts 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_breathe_pwm_pwm_core.sv
// Free-running PWM counter with period-end flag and duty compare.
// The counter is held at zero whenever the stage is disabled.
module pwm_core #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty,
    output logic                period_end,
    output logic                pwm_on
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
        end
    end

    assign period_end = en && (pwm_cnt_reg == CNT_MAX);
    assign pwm_on     = (pwm_cnt_reg < duty);

endmodule

// File: rtl/led_breathe_pwm.sv
// LED drive stage: breathing duty sequencer (ramp up, hold, ramp down, hold)
// or FOLLOW mode gating a fixed brightness with the upstream blink bit.
module led_breathe_pwm
    import led_breathe_pwm_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 64,
    parameter int HOLD_STEPS   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [PWM_BITS-1:0] level,
    input  logic                blink_in,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic                step_strobe
);

    localparam int STEP_W = cnt_width(STEP_PERIODS);
    localparam int HOLD_W = cnt_width(HOLD_STEPS);

    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_PEAK = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    led_state_t          state_reg, state_next;
    logic [PWM_BITS-1:0] duty_reg, duty_next;
    logic [STEP_W-1:0]   step_cnt_reg, step_cnt_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic                blink_q_reg;
    logic                led_reg;
    logic                step_strobe_reg;

    logic period_end;
    logic pwm_on;
    logic step_hit;
    logic mode_mismatch;
    logic mode_change;
    logic step_event;

    pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_core (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .duty       (duty_reg),
        .period_end (period_end),
        .pwm_on     (pwm_on)
    );

    assign step_hit      = period_end && (step_cnt_reg == STEP_LAST);
    assign mode_mismatch = (state_reg == ST_FOLLOW) ? (mode == MODE_BREATHE)
                                                    : (mode == MODE_FOLLOW);
    // A mode change owns its period end: counters restart and no step is taken.
    assign mode_change   = (state_reg != ST_IDLE) && period_end && mode_mismatch;
    assign step_event    = step_hit && !mode_change;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_reg       <= ST_IDLE;
            duty_reg        <= '0;
            step_cnt_reg    <= '0;
            hold_cnt_reg    <= '0;
            blink_q_reg     <= 1'b0;
            led_reg         <= 1'b0;
            step_strobe_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            duty_reg        <= duty_next;
            step_cnt_reg    <= step_cnt_next;
            hold_cnt_reg    <= hold_cnt_next;
            blink_q_reg     <= blink_in;
            led_reg         <= pwm_on && ((state_reg != ST_FOLLOW) || blink_q_reg);
            step_strobe_reg <= step_event;
        end
    end

    always_comb begin
        state_next    = state_reg;
        duty_next     = duty_reg;
        step_cnt_next = step_cnt_reg;
        hold_cnt_next = hold_cnt_reg;

        if (period_end) begin
            step_cnt_next = step_hit ? '0 : step_cnt_reg + STEP_W'(1);
        end

        if (mode_change) begin
            step_cnt_next = '0;
            hold_cnt_next = '0;
            if (mode == MODE_FOLLOW) begin
                state_next = ST_FOLLOW;
                duty_next  = level;
            end else begin
                state_next = ST_RAMP_UP;
                duty_next  = '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    duty_next  = '0;
                    state_next = (mode == MODE_FOLLOW) ? ST_FOLLOW : ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (step_event) begin
                        if (duty_reg == DUTY_PEAK) begin
                            duty_next     = DUTY_MAX;
                            hold_cnt_next = '0;
                            state_next    = ST_HOLD_HI;
                        end else begin
                            duty_next = duty_reg + PWM_BITS'(1);
                        end
                    end
                end
                ST_HOLD_HI, ST_HOLD_LO: begin
                    if (step_event) begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            hold_cnt_next = '0;
                            state_next    = (state_reg == ST_HOLD_HI) ? ST_RAMP_DOWN
                                                                      : ST_RAMP_UP;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (step_event) begin
                        if (duty_reg == DUTY_ONE) begin
                            duty_next     = '0;
                            hold_cnt_next = '0;
                            state_next    = ST_HOLD_LO;
                        end else begin
                            duty_next = duty_reg - PWM_BITS'(1);
                        end
                    end
                end
                ST_FOLLOW: begin
                    // Load only at the period boundary so a level change cannot glitch the pulse.
                    if (period_end) begin
                        duty_next = level;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    duty_next  = '0;
                end
            endcase
        end
    end

    assign led         = led_reg;
    assign duty        = duty_reg;
    assign step_strobe = step_strobe_reg;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm with PWM_BITS=4, STEP_PERIODS=2, HOLD_STEPS=3
// (PWM period 16 clk, one step every 32 clk). Outputs are sampled on the falling edge.
module tb_led_breathe_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [3:0] level;
    logic       blink_in;
    logic       led;
    logic [3:0] duty;
    logic       step_strobe;

    int checks = 0;
    int errors = 0;

    led_breathe_pwm #(
        .PWM_BITS     (4),
        .STEP_PERIODS (2),
        .HOLD_STEPS   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .level       (level),
        .blink_in    (blink_in),
        .led         (led),
        .duty        (duty),
        .step_strobe (step_strobe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Duty right after the k-th step strobe (k from 1): 15 up-steps, 3 holds,
    // 15 down-steps, 3 holds, repeating every 36 steps.
    function automatic int exp_breathe(input int k);
        int m;
        m = (k - 1) % 36;
        if (m < 15) return m + 1;
        if (m < 18) return 15;
        if (m < 33) return 14 - (m - 18);
        return 0;
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        level    = 4'd0;
        blink_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  since;
        int  k;
        int  d_win;
        int  exp_d;
        int  exp_d_prev;
        bit  exp_led;
        bit  blink_hist [0:600];
        int  first_at;
        int  second_at;
        int  first_duty;
        int  second_duty;

        // 1: reset, then held disabled
        do_reset();
        check_val("rst_led", 32'(led), 0);
        check_val("rst_duty", 32'(duty), 0);
        check_val("rst_strobe", 32'(step_strobe), 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_val("idle_led", 32'(led), 0);
            check_val("idle_duty", 32'(duty), 0);
            check_val("idle_strobe", 32'(step_strobe), 0);
        end
        $display("phase idle done checks=%0d", checks);

        // 2+3: two full breathing cycles; led pattern checked against window duty
        en    = 1'b1;
        mode  = 1'b0;
        since = 0;
        k     = 0;
        d_win = 0;
        for (int cyc = 1; cyc <= 72 * 32 + 5; cyc++) begin
            @(negedge clk);
            since++;
            exp_led = (((since - 1) % 16) < d_win);
            check_val("breathe_led", 32'(led), 32'(exp_led));
            if (step_strobe) begin
                k++;
                check_val("step_gap", 32'(since), 32);
                check_val("breathe_duty", 32'(duty), 32'(exp_breathe(k)));
                d_win = exp_breathe(k);
                since = 0;
            end
        end
        check_val("breathe_steps", 32'(k), 72);
        $display("phase breathe done steps=%0d checks=%0d", k, checks);

        // 4: FOLLOW, level 12, blink toggles every 64 clk, level changes mid-period
        do_reset();
        mode       = 1'b1;
        level      = 4'd12;
        en         = 1'b1;
        blink_in   = 1'b0;
        blink_hist[0] = 1'b0;
        exp_d      = 0;
        exp_d_prev = 0;
        for (int j = 1; j <= 512; j++) begin
            @(negedge clk);
            if (j % 16 == 0) exp_d = int'(level);
            exp_led = (((j - 1) % 16) < exp_d_prev) && ((j >= 2) ? blink_hist[j-2] : 1'b0);
            check_val("follow_led", 32'(led), 32'(exp_led));
            check_val("follow_duty", 32'(duty), 32'(exp_d));
            exp_d_prev = exp_d;
            blink_in   = ((j / 64) % 2) == 1;
            blink_hist[j] = blink_in;
            if (j == 261) level = 4'd3;
            if (j == 389) level = 4'd7;
        end
        $display("phase follow done checks=%0d", checks);

        // 5: en dropped in RAMP_DOWN at duty 9, then restart from 0
        do_reset();
        mode = 1'b0;
        en   = 1'b1;
        k    = 0;
        for (int cyc = 0; cyc < 2000 && k < 24; cyc++) begin
            @(negedge clk);
            if (step_strobe) k++;
        end
        check_val("reach_step24", 32'(k), 24);
        check_val("down_duty9", 32'(duty), 9);
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_val("endrop_duty", 32'(duty), 0);
        check_val("endrop_led", 32'(led), 0);
        check_val("endrop_strobe", 32'(step_strobe), 0);
        repeat (3) @(negedge clk);
        en          = 1'b1;
        first_at    = -1;
        second_at   = -1;
        first_duty  = -1;
        second_duty = -1;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (step_strobe) begin
                if (first_at < 0) begin
                    first_at   = j;
                    first_duty = int'(duty);
                end else if (second_at < 0) begin
                    second_at   = j;
                    second_duty = int'(duty);
                end
            end
        end
        check_val("restart_first_at", 32'(first_at), 32);
        check_val("restart_first_duty", 32'(first_duty), 1);
        check_val("restart_second_at", 32'(second_at), 64);
        check_val("restart_second_duty", 32'(second_duty), 2);
        $display("phase en_drop done checks=%0d", checks);

        // 6: rst during FOLLOW, then mode 1->0 mid-period
        do_reset();
        mode     = 1'b1;
        level    = 4'd15;
        blink_in = 1'b1;
        en       = 1'b1;
        repeat (21) @(negedge clk);
        check_val("pre_rst_duty", 32'(duty), 15);
        check_val("pre_rst_led", 32'(led), 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_led", 32'(led), 0);
        check_val("mid_rst_duty", 32'(duty), 0);
        check_val("mid_rst_strobe", 32'(step_strobe), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_val("refollow_duty", 32'(duty), 15);
        mode = 1'b0;
        for (int j = 41; j <= 90; j++) begin
            @(negedge clk);
            exp_d = (j < 48) ? 15 : ((j < 80) ? 0 : 1);
            check_val("modechg_duty", 32'(duty), 32'(exp_d));
            check_val("modechg_strobe", 32'(step_strobe), 32'(j == 80));
        end
        $display("phase mode_change done checks=%0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
